// File: rtl/i_merge4_if.sv
`default_nettype none
// ============================================================================
//  Module   : i_merge4_if
//  Purpose  : 64-bit packet stream port (valid/ready, data, last) with
//             master/slave views.
//  Revision : 1.0
// ============================================================================
interface i_merge4_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic        tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/i_merge4.sv
`default_nettype none
// ============================================================================
//  Module   : i_merge4
//  Purpose  : 4:1 packet-atomic round-robin merge with 2-entry output skid
//             buffer and optional source-index insertion into the header route.
//  Revision : 1.0
// ============================================================================
module i_merge4 #(
    parameter int ADD_ROUTE = 0
) (
    input  wire        clk,
    input  wire        reset,
    i_merge4_if.slave  i_in0,
    i_merge4_if.slave  i_in1,
    i_merge4_if.slave  i_in2,
    i_merge4_if.slave  i_in3,
    i_merge4_if.master o_out
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_grant, w_grant_nxt;
    logic [1:0]  r_last_grant, w_last_nxt;

    logic [3:0]  w_vld;
    logic [3:0]  w_lst;
    logic [63:0] w_dat [4];

    logic [1:0]  w_winner;
    logic        w_any;
    logic [1:0]  w_sel;
    logic        w_open;
    logic        w_buf_rdy;
    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_rdy_vec;
    logic        w_in_last;
    logic [63:0] w_in_data;
    logic [63:0] w_hdr_data;
    logic [63:0] w_wr_data;

    logic [64:0] r_mem [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    assign w_vld    = {i_in3.tvalid, i_in2.tvalid, i_in1.tvalid, i_in0.tvalid};
    assign w_lst    = {i_in3.tlast, i_in2.tlast, i_in1.tlast, i_in0.tlast};
    assign w_dat[0] = i_in0.tdata;
    assign w_dat[1] = i_in1.tdata;
    assign w_dat[2] = i_in2.tdata;
    assign w_dat[3] = i_in3.tdata;

    // Descending scan so the lowest offset from last_grant is assigned last and wins.
    always_comb begin
        w_winner = r_last_grant;
        w_any    = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (w_vld[r_last_grant + 2'(k)]) begin
                w_winner = r_last_grant + 2'(k);
                w_any    = 1'b1;
            end
        end
    end

    assign w_sel     = (r_state == ST_BUSY) ? r_grant : w_winner;
    assign w_open    = !reset && ((r_state == ST_BUSY) || w_any);
    assign w_buf_rdy = (r_count != 2'd2) || o_out.tready;
    assign w_rdy_vec = (w_open && w_buf_rdy) ? (4'b0001 << w_sel) : 4'b0000;
    assign w_push    = w_open && w_buf_rdy && w_vld[w_sel];
    assign w_pop     = !reset && (r_count != 2'd0) && o_out.tready;
    assign w_in_last = w_lst[w_sel];
    assign w_in_data = w_dat[w_sel];

    assign i_in0.tready = w_rdy_vec[0];
    assign i_in1.tready = w_rdy_vec[1];
    assign i_in2.tready = w_rdy_vec[2];
    assign i_in3.tready = w_rdy_vec[3];

    // Route field is shifted left by two and the source index appended; the
    // oldest two route bits fall off.
    generate
        if (ADD_ROUTE != 0) begin : g_route
            assign w_hdr_data = {w_in_data[63:56], w_in_data[53:48], w_sel, w_in_data[47:0]};
        end else begin : g_no_route
            assign w_hdr_data = w_in_data;
        end
    endgenerate

    assign w_wr_data = (r_state == ST_IDLE) ? w_hdr_data : w_in_data;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_in_last, w_wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign o_out.tvalid = !reset && (r_count != 2'd0);
    assign o_out.tdata  = r_mem[r_rptr][63:0];
    assign o_out.tlast  = r_mem[r_rptr][64];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_last_nxt = w_sel;
                    if (!w_in_last) begin
                        w_grant_nxt = w_sel;
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (w_push && w_in_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_i_merge4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i_merge4
//  Purpose  : Directed scoreboard bench; one merge with route insertion and
//             one without, both fed the same stimulus.
//  Revision : 1.0
// ============================================================================
module tb_i_merge4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ordy = 1'b1;
    logic [3:0]  vld = 4'b0;
    logic [3:0]  lst = 4'b0;
    logic [63:0] dat [4];
    logic [3:0]  en = 4'b0;
    logic        chk_lock = 1'b0;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_cnt [4];

    logic [64:0] src_q [4][$];
    logic [64:0] exp_a [$];
    logic [64:0] exp_b [$];
    int          out_cyc_q [$];

    i_merge4_if a0(), a1(), a2(), a3(), ao();
    i_merge4_if b0(), b1(), b2(), b3(), bo();

    assign a0.tvalid = vld[0]; assign a0.tdata = dat[0]; assign a0.tlast = lst[0];
    assign a1.tvalid = vld[1]; assign a1.tdata = dat[1]; assign a1.tlast = lst[1];
    assign a2.tvalid = vld[2]; assign a2.tdata = dat[2]; assign a2.tlast = lst[2];
    assign a3.tvalid = vld[3]; assign a3.tdata = dat[3]; assign a3.tlast = lst[3];
    assign b0.tvalid = vld[0]; assign b0.tdata = dat[0]; assign b0.tlast = lst[0];
    assign b1.tvalid = vld[1]; assign b1.tdata = dat[1]; assign b1.tlast = lst[1];
    assign b2.tvalid = vld[2]; assign b2.tdata = dat[2]; assign b2.tlast = lst[2];
    assign b3.tvalid = vld[3]; assign b3.tdata = dat[3]; assign b3.tlast = lst[3];
    assign ao.tready = ordy;
    assign bo.tready = ordy;

    wire [3:0] rdy = {a3.tready, a2.tready, a1.tready, a0.tready};

    i_merge4 #(.ADD_ROUTE(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_in0(a0), .i_in1(a1), .i_in2(a2), .i_in3(a3), .o_out(ao)
    );

    i_merge4 #(.ADD_ROUTE(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_in0(b0), .i_in1(b1), .i_in2(b2), .i_in3(b3), .o_out(bo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] route(input logic [63:0] d, input logic [1:0] s);
        return {d[63:56], d[53:48], s, d[47:0]};
    endfunction

    task automatic add_pkt(input int src, input int n, input logic [63:0] base);
        logic [63:0] d;
        logic        l;
        for (int k = 0; k < n; k++) begin
            d = base + 64'(k);
            l = (k == n - 1);
            src_q[src].push_back({l, d});
            exp_b.push_back({l, d});
            exp_a.push_back({l, (k == 0) ? route(d, src[1:0]) : d});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            vld[i] = en[i] && (src_q[i].size() != 0);
            if (src_q[i].size() != 0) begin
                {lst[i], dat[i]} = src_q[i][0];
            end
        end
    endtask

    // One clock: sample handshakes mid-cycle, then retire accepted beats after the edge.
    task automatic tick();
        logic [3:0] fire;
        @(negedge clk);
        fire = vld & rdy;
        if (fire[2] && acc_cnt[2] == 0) acc_cyc = cyc;
        if (chk_lock) begin
            chk("lock_i0_tready", 65'(rdy[0]), 65'd0);
            chk("lock_i3_tready", 65'(rdy[3]), 65'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) begin
                void'(src_q[i].pop_front());
                acc_cnt[i]++;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_o_tvalid_a", 65'(ao.tvalid), 65'd0);
        chk("rst_o_tvalid_b", 65'(bo.tvalid), 65'd0);
        chk("rst_in_tready", 65'(rdy), 65'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            acc_cnt[i] = 0;
        end
        exp_a.delete();
        exp_b.delete();
        en = 4'b1111;
        chk_lock = 1'b0;
        drive();
        @(negedge clk);
        chk("post_rst_o_tvalid", 65'(ao.tvalid), 65'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int i, input int n, input int max);
        int t = 0;
        while (acc_cnt[i] < n && t < max) begin
            tick();
            t++;
        end
        chk("wait_accept", 65'(acc_cnt[i] >= n), 65'd1);
    endtask

    task automatic drain(input int max);
        int t = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || src_q[0].size() != 0 ||
                src_q[1].size() != 0 || src_q[2].size() != 0 || src_q[3].size() != 0) && t < max) begin
            tick();
            t++;
        end
        chk("drain_in_time", 65'(t < max), 65'd1);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ao.tvalid && ordy) begin
                out_cyc_q.push_back(cyc);
                if (exp_a.size() == 0) chk("out_a_extra", 65'd1, 65'd0);
                else chk("out_a_beat", {ao.tlast, ao.tdata}, exp_a.pop_front());
            end
            if (bo.tvalid && ordy) begin
                if (exp_b.size() == 0) chk("out_b_extra", 65'd1, 65'd0);
                else chk("out_b_beat", {bo.tlast, bo.tdata}, exp_b.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            dat[i] = 64'd0;
            acc_cnt[i] = 0;
        end

        // Single input, route insertion, latency and back-to-back output
        do_reset();
        out_cyc_q.delete();
        add_pkt(2, 3, 64'hA505_1234_5678_9AB0);
        drive();
        drain(50);
        chk("t1_out_beats", 65'(out_cyc_q.size()), 65'd3);
        chk("t1_hdr_route", 65'(route(64'hA505_1234_5678_9AB0, 2'd2) >> 48), 65'h00A516);
        if (out_cyc_q.size() == 3) begin
            chk("t1_latency", 65'(out_cyc_q[0] - acc_cyc), 65'd1);
            chk("t1_back_to_back", 65'(out_cyc_q[2] - out_cyc_q[0]), 65'd2);
        end

        // All four contend: packets come out 0,1,2,3 then back to 0
        do_reset();
        add_pkt(0, 2, 64'h1000_0000_0000_0000);
        add_pkt(1, 2, 64'h1100_0000_0000_0100);
        add_pkt(2, 2, 64'h1200_0000_0000_0200);
        add_pkt(3, 2, 64'h1300_0000_0000_0300);
        add_pkt(0, 2, 64'h10FF_0000_0000_0400);
        drive();
        drain(100);

        // Packet lock while the granted source idles mid-packet
        do_reset();
        en = 4'b0010;
        add_pkt(1, 4, 64'h21C3_0000_0000_1000);
        add_pkt(3, 2, 64'h23C3_0000_0000_3000);
        add_pkt(0, 2, 64'h20C3_0000_0000_0000);
        drive();
        wait_acc(1, 1, 20);
        en = 4'b1011;
        chk_lock = 1'b1;
        drive();
        wait_acc(1, 2, 20);
        en = 4'b1001;
        drive();
        repeat (5) tick();
        chk("lock_i1_held", 65'(acc_cnt[1]), 65'd2);
        en = 4'b1011;
        drive();
        wait_acc(1, 4, 20);
        chk_lock = 1'b0;
        chk("lock_i0_idle", 65'(acc_cnt[0]), 65'd0);
        chk("lock_i3_idle", 65'(acc_cnt[3]), 65'd0);
        drain(100);

        // Downstream stall: two beats fill the buffer, then the source is held
        do_reset();
        ordy = 1'b0;
        add_pkt(0, 4, 64'h3000_0000_0000_0000);
        drive();
        repeat (10) tick();
        chk("bp_accepted", 65'(acc_cnt[0]), 65'd2);
        chk("bp_i0_tready", 65'(rdy[0]), 65'd0);
        chk("bp_o_tvalid", 65'(ao.tvalid), 65'd1);
        ordy = 1'b1;
        drain(100);

        // Single-beat packets alternate between two continuously valid inputs
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add_pkt(0, 1, 64'h40AA_0000_0000_0000 + 64'(k * 16));
            add_pkt(1, 1, 64'h41AA_0000_0000_0000 + 64'(k * 16));
        end
        drive();
        drain(100);

        // Reset on beat 2 of 4, then input 0 must have first priority again
        do_reset();
        add_pkt(2, 4, 64'h5200_0000_0000_0000);
        drive();
        wait_acc(2, 2, 20);
        do_reset();
        add_pkt(0, 2, 64'h60FC_0000_0000_0000);
        add_pkt(3, 2, 64'h63FC_0000_0000_3000);
        drive();
        drain(100);

        chk("end_scoreboard_empty", 65'(exp_a.size() + exp_b.size()), 65'd0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
